// File: rtl/fpga_template_pkg.sv
// Shared definitions for the ping-pong frame buffer.
//   OVERRUN_DROP / OVERRUN_ABORT : overrun policy selectors
//   rd_state_e                   : readout FSM states
//   addr_w()                     : address width for a given depth
package fpga_template_pkg;

  localparam int OVERRUN_DROP  = 0;
  localparam int OVERRUN_ABORT = 1;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PRIME  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pingpong_bank_ram.sv
// Inferred single-port RAM bank with a synchronous, read-first read port.
// The read register only updates when i_re is high, so o_rdata holds its
// value between reads.
//   i_clk   : clock
//   i_we    : write enable
//   i_re    : read enable
//   i_addr  : shared read/write address
//   i_wdata : write data
//   o_rdata : registered read data
module pingpong_bank_ram
  import fpga_template_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_addr];
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Two-bank frame buffer: CHANNELS-wide sample vectors are written into one
// bank while the previously completed frame streams out of the other over
// a valid/ready interface. Overruns are flagged and counted; OVERRUN_MODE
// picks between dropping the incoming frame and aborting the readout.
//   clk_i / rst_ni            : clock, async active-low reset
//   sample_i / sample_valid_i : input vector and write strobe
//   rd_data_o / rd_valid_o    : streamed vector and valid
//   rd_ready_i                : consumer ready
//   rd_last_o                 : final vector of a frame
//   frame_ready_o             : one-cycle pulse on bank swap
//   overrun_o / drop_cnt_o    : sticky overrun flag, saturating event count
//   clear_i                   : synchronous clear of overrun_o/drop_cnt_o
//
// state     | meaning
// RD_IDLE   | no frame pending, rd_valid_o low
// RD_PRIME  | reading address 0 of the freshly swapped bank
// RD_STREAM | rd_data_o valid, advancing on each handshake
module pingpong_frame_buffer
  import fpga_template_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 256,
  parameter int CHANNELS     = 2,
  parameter int OVERRUN_MODE = OVERRUN_DROP,
  parameter int CNT_W        = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [WIDTH*CHANNELS-1:0] sample_i,
  input  logic                      sample_valid_i,
  output logic [WIDTH*CHANNELS-1:0] rd_data_o,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic                      rd_last_o,
  output logic                      frame_ready_o,
  output logic                      overrun_o,
  output logic [CNT_W-1:0]          drop_cnt_o,
  input  logic                      clear_i
);

  localparam int DW = WIDTH * CHANNELS;
  localparam int AW = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  rd_state_e        r_state;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             r_frame_ready;
  logic             r_overrun;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_fc;
  logic             w_hs;
  logic             w_last_hs;
  logic             w_swap;
  logic             w_overrun;
  logic             w_rd_en;
  logic [AW-1:0]    w_rd_addr;
  logic [DW-1:0]    w_rd_word;
  logic [1:0]       w_bank_we;
  logic [1:0]       w_bank_re;
  logic [AW-1:0]    w_bank_addr  [2];
  logic [DW-1:0]    w_bank_rdata [2];

  assign w_fc      = sample_valid_i && (r_wr_ptr == LAST_ADDR);
  assign w_hs      = (r_state == RD_STREAM) && rd_ready_i;
  assign w_last_hs = w_hs && (r_rd_ptr == LAST_ADDR);

  // A frame completing on the same cycle the previous one finishes is a
  // clean hand-over, not an overrun.
  assign w_overrun = w_fc && (r_state != RD_IDLE) && !w_last_hs;
  assign w_swap    = w_fc && ((r_state == RD_IDLE) || w_last_hs ||
                              (OVERRUN_MODE == OVERRUN_ABORT));

  // Reads happen only on prime or handshake so the bank output register
  // holds the current vector through a stall.
  assign w_rd_en   = (r_state == RD_PRIME) || (w_hs && (r_rd_ptr != LAST_ADDR));
  assign w_rd_addr = (r_state == RD_PRIME) ? '0 : (r_rd_ptr + AW'(1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_bank_we[b]   = sample_valid_i && (r_wr_bank == 1'(b));
    assign w_bank_re[b]   = w_rd_en && (r_rd_bank == 1'(b));
    assign w_bank_addr[b] = w_bank_we[b] ? r_wr_ptr : w_rd_addr;

    pingpong_bank_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_ram (
      .i_clk   (clk_i),
      .i_we    (w_bank_we[b]),
      .i_re    (w_bank_re[b]),
      .i_addr  (w_bank_addr[b]),
      .i_wdata (sample_i),
      .o_rdata (w_bank_rdata[b])
    );
  end

  // Write pointer wraps naturally at DEPTH (power of two); on a dropped
  // frame the same bank is simply refilled from address 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
    end else if (sample_valid_i) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= RD_IDLE;
      r_rd_ptr      <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b1;
      r_frame_ready <= 1'b0;
    end else begin
      r_frame_ready <= w_swap;
      if (w_swap) begin
        r_wr_bank <= ~r_wr_bank;
        r_rd_bank <= r_wr_bank;
        r_rd_ptr  <= '0;
        r_state   <= RD_PRIME;
      end else begin
        case (r_state)
          RD_PRIME: r_state <= RD_STREAM;
          RD_STREAM: begin
            if (w_hs) begin
              if (r_rd_ptr == LAST_ADDR) r_state <= RD_IDLE;
              else                       r_rd_ptr <= r_rd_ptr + AW'(1);
            end
          end
          default: r_state <= RD_IDLE;
        endcase
      end
    end
  end

  // An overrun coinciding with clear_i leaves one recorded event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear_i) begin
      r_overrun  <= w_overrun;
      r_drop_cnt <= w_overrun ? CNT_W'(1) : '0;
    end else if (w_overrun) begin
      r_overrun <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign w_rd_word     = r_rd_bank ? w_bank_rdata[1] : w_bank_rdata[0];
  assign rd_valid_o    = (r_state == RD_STREAM);
  assign rd_data_o     = rd_valid_o ? w_rd_word : '0;
  assign rd_last_o     = rd_valid_o && (r_rd_ptr == LAST_ADDR);
  assign frame_ready_o = r_frame_ready;
  assign overrun_o     = r_overrun;
  assign drop_cnt_o    = r_drop_cnt;

endmodule
